// File: rtl/demux_1to8_tdm_if.sv
// demux_1to8_tdm_if: serial beat input and parallel frame output bundle for demux_1to8_tdm
interface demux_1to8_tdm_if;
    logic       D;
    logic       valid;
    logic       sof;
    logic       Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [2:0] S;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;
    modport master (
        output D, valid, sof,
        input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, S, frame_valid, frame_err, busy
    );
    modport slave (
        input  D, valid, sof,
        output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, S, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/demux_1to8_tdm.sv
// demux_1to8_tdm: collects 8 serial beats into a shadow register and publishes them as a held parallel frame
module demux_1to8_tdm #(
    parameter bit FREE_RUN = 1'b0
) (
    input logic clk,
    input logic rst_n,
    demux_1to8_tdm_if.slave bus
);
    typedef enum logic {IDLE, RECV} state_t;
    state_t     state, state_n;
    logic [2:0] s, s_n;
    logic [7:0] sh, sh_n, y, y_n;
    logic       fv, fv_n, fe, fe_n;
    logic       start, abort;
    assign start = bus.valid && (bus.sof || FREE_RUN);
    assign abort = bus.valid && bus.sof && !FREE_RUN;
    always_comb begin
        state_n = state;
        s_n     = s;
        sh_n    = sh;
        y_n     = y;
        fv_n    = 1'b0;
        fe_n    = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                sh_n    = {7'b0, bus.D};
                s_n     = 3'd1;
                state_n = RECV;
            end
        end else if (bus.valid) begin
            // a sof beat restarts the frame, even on the slot that would have completed it
            if (abort) begin
                fe_n = 1'b1;
                sh_n = {7'b0, bus.D};
                s_n  = 3'd1;
            end else if (s == 3'd7) begin
                y_n     = {bus.D, sh[6:0]};
                fv_n    = 1'b1;
                s_n     = 3'd0;
                state_n = IDLE;
            end else begin
                sh_n[s] = bus.D;
                s_n     = s + 3'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= 3'd0;
            sh    <= 8'd0;
            y     <= 8'd0;
            fv    <= 1'b0;
            fe    <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            sh    <= sh_n;
            y     <= y_n;
            fv    <= fv_n;
            fe    <= fe_n;
        end
    end
    assign bus.Y0          = y[0];
    assign bus.Y1          = y[1];
    assign bus.Y2          = y[2];
    assign bus.Y3          = y[3];
    assign bus.Y4          = y[4];
    assign bus.Y5          = y[5];
    assign bus.Y6          = y[6];
    assign bus.Y7          = y[7];
    assign bus.S           = s;
    assign bus.frame_valid = fv;
    assign bus.frame_err   = fe;
    assign bus.busy        = (state == RECV);
endmodule

// File: doc/demux_1to8_tdm.md
# demux_1to8_tdm

Time-division 1-to-8 demultiplexer: the receive-side counterpart of the 8-to-1 mux. It accepts one serial data bit per valid beat, steers it into slot 0..7 under an internal 3-bit slot counter, and on the 8th beat publishes all eight bits at once on held outputs Y0..Y7 with a one-cycle frame pulse. It sits between a serial link carrying mux-selected frames and logic that needs the eight lines in parallel.

## Interface
- FREE_RUN, default 0: 0 = a frame starts only on a beat with sof=1; 1 = any valid beat in IDLE starts a frame, and sof is ignored everywhere.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  1  serial data bit for the current slot.
- valid  input  1  D (and sof) are sampled on this cycle's rising edge.
- sof  input  1  start of frame; meaningful only when valid=1.
- Y0..Y7  output  1 each  last complete frame; Y0 = first beat, Y7 = eighth beat; registered and held.
- S  output  3  slot index the next valid beat will fill; 0 in IDLE.
- frame_valid  output  1  one-cycle pulse: Y0..Y7 were just updated.
- frame_err  output  1  one-cycle pulse: a partial frame was aborted by sof.
- busy  output  1  high in RECV (frame partially received).

## Operation
- States: IDLE, RECV. Shadow register sh[7:0] collects bits; Y0..Y7 change only at frame completion (double-buffered).
- IDLE: valid && (sof || FREE_RUN) -> sh[0]<=D, S<=1, go RECV. valid without sof (FREE_RUN=0) -> beat dropped, stay IDLE, no pulse.
- RECV, valid, no abort: sh[S]<=D, S<=S+1.
  - If S==7: {Y7..Y0}<={D, sh[6:0]}, frame_valid<=1, S wraps to 0, go IDLE.
- RECV, valid && sof (FREE_RUN=0): abort partial frame; frame_err<=1; the same beat is slot 0 of the new frame: sh[0]<=D, S<=1, stay RECV. Y unchanged.
- sof on slot 7 beat (S==7) counts as abort, not completion: frame_err=1, frame_valid=0, new frame at slot 1.
- valid=0: all state holds; no timeout, gaps of any length are legal.
- Back-to-back frames: a sof beat on the cycle after completion is accepted normally (IDLE reached by then); no dead cycle required.
- sof with valid=0 is ignored.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, S=0, sh=0, Y0..Y7=0, frame_valid=0, frame_err=0, busy=0.
- Reset mid-frame: partial frame discarded, previously published Y cleared to 0, no pulse.
- Latency: Y0..Y7 and frame_valid update at the edge sampling the 8th beat; visible the cycle after it. Minimum 8 cycles from first beat to frame_valid.
- frame_valid and frame_err are exactly one cycle wide, registered, never both high.
- busy = (state==RECV), registered; S registered, always equals number of bits held in sh.

## Test plan
- Reset, then sof+8 contiguous beats D=1,0,1,1,0,0,1,0 -> after 8th edge Y0..Y7=1,0,1,1,0,0,1,0, frame_valid high 1 cycle, S=0, busy=0.
- Same frame with valid=0 gaps of 3 cycles between beats -> identical Y, frame_valid only after 8th valid beat; S steps 1..7 only on valid beats.
- 5 beats, then sof beat D=1 + 7 beats all 0 -> frame_err pulse on the sof beat, then Y0=1, Y1..Y7=0, one frame_valid.
- FREE_RUN=0: 4 valid beats without sof in IDLE -> no state change, S=0; FREE_RUN=1: 8 beats without sof -> frame published.
- Two back-to-back frames 8'hA5 then 8'h3C (LSB first) with no idle cycle -> two frame_valid pulses 8 cycles apart, Y matches each.
- rst_n asserted after 4 beats -> Y all 0, S=0, busy=0 immediately; next sof frame decodes correctly.
